// File: rtl/handshake_tx.sv
// handshake_tx: FIFO-buffered ready/valid transmitter with registered tag.
// Words leave in push order; a saturating counter tracks completed transfers.
module handshake_tx #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     handshake_valid,
  input  logic                     handshake_ready,
  output logic [WIDTH-1:0]         in1,
  output logic                     out,
  output logic [CNT_W-1:0]         count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    pending;
  logic             push;
  logic             pop;
  logic             load;
  logic [WIDTH-1:0] head;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign push_ready = RESETN && (level != FULL);
  assign push       = push_valid && push_ready;
  assign pop        = handshake_valid && handshake_ready;

  // Words stored but not yet moved into the output register.
  assign pending = level - LW'(handshake_valid);
  assign head    = mem[rd_ptr];
  assign load    = (pending != '0) && (!handshake_valid || pop);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      handshake_valid <= 1'b0;
      in1             <= '0;
      out             <= 1'b0;
      count           <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      level <= level + LW'(push) - LW'(pop);
      if (load) begin
        rd_ptr          <= rd_ptr + PW'(1);
        in1             <= head;
        out             <= (|head) && (&head);
        handshake_valid <= 1'b1;
      end else if (pop) begin
        handshake_valid <= 1'b0;
      end
      if (pop && (count != CNT_MAX)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/handshake_tx.md
Name: handshake_tx

Overview:
- Transmitter end of the single-lane ready/valid handshake checked by the bound assertion monitor.
- Buffers 4-bit words pushed by a local producer in a small FIFO and presents them one at a time on the handshake.
- Drives a registered tag alongside each word: the tag equals OR-reduce(word) AND AND-reduce(word), which is exactly the relation the downstream monitor asserts.
- Keeps a saturating count of completed transfers for debug.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- WIDTH, 4, data word width.
- CNT_W, 8, width of the transfer counter.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RESETN  input  1  synchronous, active-low reset.
- push_valid  input  1  producer offers push_data this cycle.
- push_ready  output  1  FIFO can accept a word (not full).
- push_data  input  WIDTH  producer word.
- handshake_valid  output  1  word presented downstream.
- handshake_ready  input  1  downstream accepts.
- in1  output  WIDTH  presented word.
- out  output  1  tag for the presented word: (|in1) && (&in1).
- count  output  CNT_W  completed downstream transfers, saturating.
- level  output  clog2(DEPTH)+1  number of occupied FIFO entries, including the presented word.

Behaviour:
- Reset (RESETN=0 at a rising edge):
  - pointers and level clear to 0; handshake_valid=0; in1=0; out=0; count=0.
  - push_ready=0 during the reset cycle.
  - Reset applied mid-transfer drops all buffered words; no transfer completes in that cycle even if handshake_ready=1.
- Push: accepted when push_valid && push_ready. push_ready = (level != DEPTH) and is combinational from state only, never from push_valid.
- Pop: occurs when handshake_valid && handshake_ready.
- Output register:
  - in1, out and handshake_valid are registered. in1/out are the head entry, loaded when the output slot is empty or being popped.
  - Zero-bubble: with a continuous stream and handshake_ready held high, one word transfers every cycle.
- Latency: a word pushed into an empty FIFO at edge N is presented (handshake_valid=1) after edge N+1. No combinational path from push to handshake_valid.
- Stability rule: while handshake_valid=1 and handshake_ready=0, in1, out and handshake_valid hold their values. handshake_valid never drops without a pop.
- Tag: out is computed from the stored word when it is loaded, never from push_data in the same cycle. For WIDTH=4, out=1 only for 4'hF.
- level accounting:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both honoured.
  - When full with a simultaneous pop, push_ready stays 0 (registered full). No same-cycle pass-through.
- Empty: handshake_valid=0; in1 and out hold their last values and must not be relied upon.
- Pointers: DEPTH-modulo wrap; the full/empty distinction comes from level, not from pointer equality.
- count: increments by 1 per pop and saturates at 2^CNT_W-1 without wrapping.
- Words leave in strict push order.

Test Plan:
- Reset then idle: hold RESETN=0 for 2 cycles, release, no pushes -> handshake_valid=0, in1=0, out=0, count=0, level=0, push_ready=1 from the first cycle after release.
- Single word: push 4'hF at edge 1 with handshake_ready=1 -> handshake_valid=1 after edge 2 with in1=F, out=1; pop at edge 3; count=1, level=0.
- Backpressure: push 4'h3, 4'hF, 4'h0, 4'h8 with handshake_ready=0 -> level=4, push_ready=0, in1=3 and out=0 stable for 10 cycles. Then raise handshake_ready -> words 3, F, 0, 8 on 4 consecutive cycles with out=0,1,0,0; count=4.
- Full plus simultaneous pop: with FIFO full, assert push_valid and handshake_ready together -> push rejected that cycle, level=3. Next cycle, push and pop both accepted -> level stays 3.
- Streaming wrap: 20 back-to-back pushes 0..F,0..3 with handshake_ready=1 -> 20 in-order transfers at one per cycle after the 1-cycle latency; pointers wrap; count=20.
- Reset mid-stream: drop RESETN with level=3 and handshake_ready=1 -> the next cycle shows handshake_valid=0, level=0, count=0, and the dropped words are never transmitted.
